// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared vertical-state encoding and default 1024x768 timing
//               constants for the VGA line/frame timing chain.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Vertical timing state; UNLOCKED until the first line start is seen
    typedef enum logic [2:0] {
        UNLOCKED = 3'd0,
        V_ACT    = 3'd1,
        V_FP     = 3'd2,
        V_SY     = 3'd3,
        V_BP     = 3'd4
    } vstate_t;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_TOTAL  = 1328;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FRONT  = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BACK   = 29;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/rising_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : rising_edge_detector
// Description : Registers a same-domain signal and flags its rising edge.
//               A signal already high when reset releases reads as a rise.
// Revision    : 1.0 - initial release
// ============================================================================
module rising_edge_detector (
    input  logic control_clock,
    input  logic reset_n,
    input  logic sig,
    output logic rise,
    output logic sig_q
);

    // One-cycle delayed copy of the input for edge comparison
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule : rising_edge_detector
`default_nettype wire

// File: rtl/vga_line_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_frame_timer
// Description : Follows the horizontal sync waveform and produces pixel
//               position, line index, vertical sync, display enable and
//               line/frame markers, with a missing-edge lock monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_line_frame_timer
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE      = DEF_H_ACTIVE,
    parameter int   H_TOTAL       = DEF_H_TOTAL,
    parameter int   V_ACTIVE      = DEF_V_ACTIVE,
    parameter int   V_FRONT       = DEF_V_FRONT,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BACK        = DEF_V_BACK,
    parameter logic V_SYNC_ACTIVE = 1'b0,
    parameter int   X_WIDTH       = 11,
    parameter int   Y_WIDTH       = 10
) (
    input  logic               control_clock,
    input  logic               reset_n,
    input  logic               h_sync,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               display_enable,
    output logic               v_sync,
    output logic               line_start,
    output logic               frame_start,
    output logic               locked
);

    localparam logic [X_WIDTH-1:0] X_LAST    = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] X_ACT_END = X_WIDTH'(H_ACTIVE);
    localparam logic [Y_WIDTH-1:0] Y_ACT_LST = Y_WIDTH'(V_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] Y_FP_LST  = Y_WIDTH'(V_FRONT - 1);
    localparam logic [Y_WIDTH-1:0] Y_SY_LST  = Y_WIDTH'(V_SYNC - 1);
    localparam logic [Y_WIDTH-1:0] Y_BP_LST  = Y_WIDTH'(V_BACK - 1);

    vstate_t            state;
    vstate_t            nxt_state;
    logic [X_WIDTH-1:0] nxt_x;
    logic [Y_WIDTH-1:0] nxt_y;
    logic [Y_WIDTH-1:0] last_y;
    logic               nxt_locked;
    logic               nxt_frame;
    logic               rise;
    logic               h_sync_q;

    rising_edge_detector u_hsync_edge (
        .control_clock (control_clock),
        .reset_n       (reset_n),
        .sig           (h_sync),
        .rise          (rise),
        .sig_q         (h_sync_q)
    );

    // Last line index of the current vertical state
    always_comb begin
        last_y = '0;
        case (state)
            V_ACT:   last_y = Y_ACT_LST;
            V_FP:    last_y = Y_FP_LST;
            V_SY:    last_y = Y_SY_LST;
            V_BP:    last_y = Y_BP_LST;
            default: last_y = '0;
        endcase
    end

    // Next-state, counters and lock: a rise always wins over a timeout
    always_comb begin
        nxt_state  = state;
        nxt_x      = pixel_x;
        nxt_y      = pixel_y;
        nxt_locked = locked;
        nxt_frame  = 1'b0;
        if (rise) begin
            nxt_x = '0;
            if (state == UNLOCKED) begin
                nxt_state  = V_ACT;
                nxt_y      = '0;
                nxt_locked = 1'b1;
                nxt_frame  = 1'b1;
            end else if (pixel_y == last_y) begin
                nxt_y = '0;
                case (state)
                    V_ACT:   nxt_state = V_FP;
                    V_FP:    nxt_state = V_SY;
                    V_SY:    nxt_state = V_BP;
                    V_BP: begin
                        nxt_state = V_ACT;
                        nxt_frame = 1'b1;
                    end
                    default: nxt_state = UNLOCKED;
                endcase
            end else begin
                nxt_y = pixel_y + 1'b1;
            end
        end else if (pixel_x < X_LAST) begin
            nxt_x = pixel_x + 1'b1;
        end else begin
            // Line overran its expected length without an edge
            nxt_state  = UNLOCKED;
            nxt_locked = 1'b0;
            nxt_y      = '0;
        end
    end

    // State and registered outputs, all aligned with pixel_x
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= UNLOCKED;
            pixel_x        <= '0;
            pixel_y        <= '0;
            locked         <= 1'b0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
            v_sync         <= ~V_SYNC_ACTIVE;
            display_enable <= 1'b0;
        end else begin
            state          <= nxt_state;
            pixel_x        <= nxt_x;
            pixel_y        <= nxt_y;
            locked         <= nxt_locked;
            line_start     <= rise;
            frame_start    <= nxt_frame;
            v_sync         <= (nxt_state == V_SY) ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
            display_enable <= nxt_locked && (nxt_state == V_ACT) && (nxt_x < X_ACT_END);
        end
    end

endmodule : vga_line_frame_timer
`default_nettype wire

// File: tb/tb_vga_line_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_line_frame_timer
// Description : Scoreboard bench for vga_line_frame_timer on a miniature
//               20-clock line / 8-line frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_line_frame_timer;

    localparam int X_WIDTH = 5;
    localparam int Y_WIDTH = 3;

    logic               control_clock = 1'b0;
    logic               reset_n       = 1'b1;
    logic               h_sync        = 1'b0;
    logic [X_WIDTH-1:0] pixel_x;
    logic [Y_WIDTH-1:0] pixel_y;
    logic               display_enable;
    logic               v_sync;
    logic               line_start;
    logic               frame_start;
    logic               locked;

    typedef struct {
        logic [2:0] y;
        logic       vs;
        logic       fs;
        logic       de;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   fs_cycles[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic cur_de = 1'b0;

    // Hand-computed expectations for lines 0..9 of the first frame run
    int                  t_y[10] = '{0, 1, 2, 3, 0, 0, 1, 0, 0, 1};
    localparam logic [9:0] T_VS  = 10'b1110011111;
    localparam logic [9:0] T_FS  = 10'b0100000001;
    localparam logic [9:0] T_DE  = 10'b1100001111;

    vga_line_frame_timer #(
        .H_ACTIVE      (12),
        .H_TOTAL       (20),
        .V_ACTIVE      (4),
        .V_FRONT       (1),
        .V_SYNC        (2),
        .V_BACK        (1),
        .V_SYNC_ACTIVE (1'b0),
        .X_WIDTH       (X_WIDTH),
        .Y_WIDTH       (Y_WIDTH)
    ) dut (
        .control_clock  (control_clock),
        .reset_n        (reset_n),
        .h_sync         (h_sync),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .display_enable (display_enable),
        .v_sync         (v_sync),
        .line_start     (line_start),
        .frame_start    (frame_start),
        .locked         (locked)
    );

    always #5 control_clock = ~control_clock;

    always @(posedge control_clock) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [2:0] y, input logic vs, input logic fs, input logic de);
        exp_t e;
        e.y  = y;
        e.vs = vs;
        e.fs = fs;
        e.de = de;
        exp_q.push_back(e);
    endtask

    // One h_sync period; called and returns on a falling clock edge
    task automatic drive_line(input int hi, input int lo, input logic [2:0] y,
                              input logic vs, input logic fs, input logic de);
        push_exp(y, vs, fs, de);
        h_sync = 1'b1;
        repeat (hi) @(negedge control_clock);
        h_sync = 1'b0;
        repeat (lo) @(negedge control_clock);
    endtask

    // Monitor: pops one expectation per line_start, plus per-cycle checks
    always @(negedge control_clock) begin
        if (line_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_line_start actual 1 required 0");
            end else begin
                mon_e = exp_q.pop_front();
                check("ls_pixel_x", 32'(pixel_x), 0);
                check("ls_pixel_y", 32'(pixel_y), 32'(mon_e.y));
                check("ls_v_sync", 32'(v_sync), 32'(mon_e.vs));
                check("ls_frame_start", 32'(frame_start), 32'(mon_e.fs));
                check("ls_locked", 32'(locked), 1);
                check("ls_display_enable", 32'(display_enable), 32'(mon_e.de));
                cur_de = mon_e.de;
            end
            if (frame_start === 1'b1) fs_cycles.push_back(cyc);
        end else begin
            check("frame_start_without_line_start", 32'(frame_start), 0);
        end
        if (locked === 1'b1 && pixel_x == 5'd11)
            check("de_at_x11", 32'(display_enable), 32'(cur_de));
        if (locked === 1'b1 && pixel_x == 5'd12)
            check("de_at_x12", 32'(display_enable), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset with no clock edge yet
        #1 reset_n = 1'b0;
        #2;
        check("rst_pixel_x", 32'(pixel_x), 0);
        check("rst_pixel_y", 32'(pixel_y), 0);
        check("rst_display_enable", 32'(display_enable), 0);
        check("rst_v_sync", 32'(v_sync), 1);
        check("rst_line_start", 32'(line_start), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_locked", 32'(locked), 0);

        #10 reset_n = 1'b1;
        @(negedge control_clock);
        repeat (4) @(negedge control_clock);
        check("prelock_locked", 32'(locked), 0);
        check("prelock_de", 32'(display_enable), 0);

        // Full frame plus the next frame start
        for (int i = 0; i < 9; i++)
            drive_line(16, 4, 3'(t_y[i]), T_VS[i], T_FS[i], T_DE[i]);
        if (fs_cycles.size() < 2)
            check("frame_start_count", fs_cycles.size(), 2);
        else
            check("frame_period", fs_cycles[1] - fs_cycles[0], 160);

        // Missing edge: saturate then lose lock
        drive_line(16, 0, 3'(t_y[9]), T_VS[9], T_FS[9], T_DE[9]);
        repeat (4) @(negedge control_clock);
        check("sat_pixel_x", 32'(pixel_x), 19);
        check("sat_locked", 32'(locked), 1);
        @(negedge control_clock);
        check("lost_locked", 32'(locked), 0);
        check("lost_de", 32'(display_enable), 0);
        check("lost_pixel_x", 32'(pixel_x), 19);
        repeat (2) @(negedge control_clock);
        check("unlocked_pixel_x_hold", 32'(pixel_x), 19);
        check("unlocked_v_sync", 32'(v_sync), 1);
        check("unlocked_pixel_y", 32'(pixel_y), 0);

        // Relock, then a 15-clock short line
        drive_line(11, 4, 3'd0, 1'b1, 1'b1, 1'b1);
        check("short_pixel_x", 32'(pixel_x), 14);
        check("short_locked", 32'(locked), 1);
        drive_line(16, 4, 3'd1, 1'b1, 1'b0, 1'b1);
        drive_line(16, 4, 3'd2, 1'b1, 1'b0, 1'b1);
        drive_line(16, 4, 3'd3, 1'b1, 1'b0, 1'b1);
        drive_line(16, 4, 3'd0, 1'b1, 1'b0, 1'b0);
        drive_line(16, 1, 3'd0, 1'b0, 1'b0, 1'b0);
        check("mid_vsy_v_sync", 32'(v_sync), 0);

        // Reset in the middle of the sync pulse, off the clock edge
        #2 reset_n = 1'b0;
        #1;
        check("midrst_v_sync", 32'(v_sync), 1);
        check("midrst_pixel_x", 32'(pixel_x), 0);
        check("midrst_pixel_y", 32'(pixel_y), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_line_start", 32'(line_start), 0);
        check("midrst_frame_start", 32'(frame_start), 0);
        check("midrst_de", 32'(display_enable), 0);
        @(posedge control_clock);
        #2 reset_n = 1'b1;
        @(negedge control_clock);
        repeat (3) @(negedge control_clock);
        check("postrst_locked", 32'(locked), 0);
        drive_line(16, 4, 3'd0, 1'b1, 1'b1, 1'b1);

        // h_sync already high when reset releases
        #2 reset_n = 1'b0;
        h_sync = 1'b1;
        push_exp(3'd0, 1'b1, 1'b1, 1'b1);
        @(posedge control_clock);
        #2 reset_n = 1'b1;
        @(posedge control_clock);
        @(negedge control_clock);
        check("release_high_line_start", 32'(line_start), 1);
        check("release_high_locked", 32'(locked), 1);
        repeat (15) @(negedge control_clock);
        h_sync = 1'b0;
        repeat (6) @(negedge control_clock);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vga_line_frame_timer
`default_nettype wire
